// File: rtl/vc_demux.sv
// vc_demux: steers one incoming word stream into four virtual-channel FIFOs by class field.
// Latency: 1 cycle from accepted input to push strobe; stalled words release 1 cycle after full drops.
// Backpressure: pause is combinational from state, enb and any almost-full flag; one-word stall buffer.
//
// Ports:
//   clk, rst (async, active-low), enb (freezes accept/push when 0)
//   data_in/valid_in           : upstream word stream
//   full_vchannel0..3          : per-VC FIFO full flags (decide push vs. stall)
//   almost_full_vchannel0..3   : per-VC FIFO almost-full flags (raise pause)
//   data_out/push_vchannel     : registered shared write bus and one-hot push strobes
//   pause                      : backpressure to upstream
//   error                      : sticky, set when a word arrives while pause is high
//   state                      : FSM state for debug (0 RESET, 1 IDLE, 2 STALL, 3 DRAIN)
//   push_count                 : only with VC_DEMUX_STATS_EN; four 8-bit wrapping push counters
//
// Optional feature macro: VC_DEMUX_STATS_EN adds per-VC push counters on push_count.

module vc_demux #(
  parameter int DATA_WIDTH = 6,
  parameter int CLASS_LSB  = DATA_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  full_vchannel0,
  input  logic                  full_vchannel1,
  input  logic                  full_vchannel2,
  input  logic                  full_vchannel3,
  input  logic                  almost_full_vchannel0,
  input  logic                  almost_full_vchannel1,
  input  logic                  almost_full_vchannel2,
  input  logic                  almost_full_vchannel3,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [3:0]            push_vchannel,
  output logic                  pause,
  output logic                  error,
`ifdef VC_DEMUX_STATS_EN
  output logic [31:0]           push_count,
`endif
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_STALL = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                st_q, st_nxt;
  logic [DATA_WIDTH-1:0] dout_q, dout_nxt;
  logic [DATA_WIDTH-1:0] hold_q, hold_nxt;
  logic [3:0]            push_q, push_nxt;
  logic                  err_q, err_nxt;

  logic [3:0] full_vec;
  logic       af_any;
  logic [1:0] in_sel;
  logic [1:0] hold_sel;
  logic       accept;
  logic       violation;

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    onehot = 4'b0001 << sel;
  endfunction

  assign full_vec = {full_vchannel3, full_vchannel2, full_vchannel1, full_vchannel0};
  assign af_any   = almost_full_vchannel0 | almost_full_vchannel1 |
                    almost_full_vchannel2 | almost_full_vchannel3;

  assign in_sel   = data_in[CLASS_LSB+1:CLASS_LSB];
  assign hold_sel = hold_q[CLASS_LSB+1:CLASS_LSB];

  // Anything other than IDLE pauses upstream, so a stalled word's release
  // can never collide with a fresh input word.
  assign pause  = (st_q != ST_IDLE) | ~enb | af_any;
  assign accept = valid_in & enb & ~pause;

  // Upstream ignoring pause is a protocol error; the word is simply dropped.
  // During RESET pause is forced high, so words there are not flagged.
  assign violation = valid_in & pause & (st_q != ST_RESET);

  // Next-state and next-output logic
  always_comb begin
    st_nxt   = st_q;
    dout_nxt = dout_q;
    hold_nxt = hold_q;
    push_nxt = 4'b0000;
    err_nxt  = err_q | violation;

    unique case (st_q)
      ST_RESET: begin
        st_nxt = ST_IDLE;
      end

      ST_IDLE: begin
        if (accept) begin
          if (!full_vec[in_sel]) begin
            push_nxt = onehot(in_sel);
            dout_nxt = data_in;
          end else begin
            hold_nxt = data_in;
            st_nxt   = ST_STALL;
          end
        end
      end

      ST_STALL: begin
        if (enb && !full_vec[hold_sel]) begin
          push_nxt = onehot(hold_sel);
          dout_nxt = hold_q;
          st_nxt   = ST_DRAIN;
        end
      end

      // One dead cycle so the FIFO's flags reflect the released word.
      ST_DRAIN: begin
        if (enb) begin
          st_nxt = ST_IDLE;
        end
      end

      default: begin
        st_nxt = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= ST_RESET;
      dout_q <= '0;
      hold_q <= '0;
      push_q <= 4'b0000;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_nxt;
      dout_q <= dout_nxt;
      hold_q <= hold_nxt;
      push_q <= push_nxt;
      err_q  <= err_nxt;
    end
  end

  assign data_out      = dout_q;
  assign push_vchannel = push_q;
  assign error         = err_q;
  assign state         = st_q;

`ifdef VC_DEMUX_STATS_EN
  // Counters follow the registered strobe, so they only see words that were
  // actually pushed; dropped words never reach push_q.
  logic [7:0] cnt_q [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q[gi] <= 8'd0;
      end else if (push_q[gi]) begin
        cnt_q[gi] <= cnt_q[gi] + 8'd1;
      end
    end
  end

  assign push_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_vc_demux.sv
module tb_vc_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [5:0] data_in;
  logic       valid_in;
  logic       f0, f1, f2, f3;
  logic       af0, af1, af2, af3;
  logic [5:0] data_out;
  logic [3:0] push;
  logic       pause;
  logic       error;
  logic [1:0] state;
`ifdef VC_DEMUX_STATS_EN
  logic [31:0] push_count;
`endif

  typedef struct packed {
    logic [3:0] p;
    logic [5:0] d;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  vc_demux #(.DATA_WIDTH(6)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enb                   (enb),
    .data_in               (data_in),
    .valid_in              (valid_in),
    .full_vchannel0        (f0),
    .full_vchannel1        (f1),
    .full_vchannel2        (f2),
    .full_vchannel3        (f3),
    .almost_full_vchannel0 (af0),
    .almost_full_vchannel1 (af1),
    .almost_full_vchannel2 (af2),
    .almost_full_vchannel3 (af3),
    .data_out              (data_out),
    .push_vchannel         (push),
    .pause                 (pause),
    .error                 (error),
`ifdef VC_DEMUX_STATS_EN
    .push_count            (push_count),
`endif
    .state                 (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and check any push against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    chk("push_onehot0", {31'd0, $onehot0(push)}, 32'd1);
    if (push !== 4'b0000) begin
      chk("push_expected", {31'd0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("push_vec", {28'd0, push}, {28'd0, e.p});
        chk("push_data", {26'd0, data_out}, {26'd0, e.d});
      end
    end
  endtask

  task automatic expect_push(input logic [5:0] w);
    exp_t e;
    e.p = 4'b0001 << w[5:4];
    e.d = w;
    q.push_back(e);
  endtask

  initial begin
    logic [5:0] words [4];
    words[0] = 6'b00_0101;
    words[1] = 6'b01_1010;
    words[2] = 6'b10_0011;
    words[3] = 6'b11_1111;

    rst = 1'b0; enb = 1'b1; data_in = '0; valid_in = 1'b0;
    f0 = 0; f1 = 0; f2 = 0; f3 = 0;
    af0 = 0; af1 = 0; af2 = 0; af3 = 0;

    // Reset held for three cycles
    repeat (3) step();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_pause", {31'd0, pause}, 32'd1);
    chk("rst_push", {28'd0, push}, 32'd0);
    chk("rst_data", {26'd0, data_out}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b1;
    step();
    chk("idle_state", {30'd0, state}, 32'd1);
    chk("idle_pause", {31'd0, pause}, 32'd0);

    // Routing: back-to-back words to all four VCs
    for (int i = 0; i < 4; i++) begin
      data_in = words[i]; valid_in = 1'b1;
      expect_push(words[i]);
      step();
    end
    valid_in = 1'b0;
    step();
    chk("route_drained", q.size(), 32'd0);

    // Full stall on vchannel2
    f2 = 1'b1;
    data_in = 6'b10_0110; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("stall_push", {28'd0, push}, 32'd0);
    chk("stall_state", {30'd0, state}, 32'd2);
    chk("stall_pause", {31'd0, pause}, 32'd1);
    repeat (3) step();
    chk("stall_hold_state", {30'd0, state}, 32'd2);
    f2 = 1'b0;
    expect_push(6'b10_0110);
    step();
    chk("release_state", {30'd0, state}, 32'd3);
    chk("drain_pause", {31'd0, pause}, 32'd1);
    step();
    chk("drain_done_state", {30'd0, state}, 32'd1);
    chk("drain_done_pause", {31'd0, pause}, 32'd0);
    chk("stall_no_error", {31'd0, error}, 32'd0);

    // Almost-full backpressure and protocol violation
    af1 = 1'b1;
    #1;
    chk("af_pause", {31'd0, pause}, 32'd1);
    data_in = 6'b01_0001; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("viol_error", {31'd0, error}, 32'd1);
    af1 = 1'b0;
    step();
    step();
    chk("error_sticky", {31'd0, error}, 32'd1);
    chk("af_clear_pause", {31'd0, pause}, 32'd0);

    // Enable freeze during STALL
    f0 = 1'b1;
    data_in = 6'b00_1100; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("frz_stall_state", {30'd0, state}, 32'd2);
    f0 = 1'b0; enb = 1'b0;
    step();
    step();
    chk("frz_state_held", {30'd0, state}, 32'd2);
    chk("frz_pause", {31'd0, pause}, 32'd1);
    enb = 1'b1;
    expect_push(6'b00_1100);
    step();
    chk("frz_release_state", {30'd0, state}, 32'd3);
    step();
    chk("frz_idle", {30'd0, state}, 32'd1);

    // Reset asserted mid-STALL discards the held word
    f1 = 1'b1;
    data_in = 6'b01_0111; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("mid_stall_state", {30'd0, state}, 32'd2);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk("mid_rst_pause", {31'd0, pause}, 32'd1);
    chk("mid_rst_data", {26'd0, data_out}, 32'd0);
    chk("mid_rst_error", {31'd0, error}, 32'd0);
    step();
    rst = 1'b1;
    step();
    f1 = 1'b0;
    step();
    step();
    chk("mid_rst_idle", {30'd0, state}, 32'd1);

`ifdef VC_DEMUX_STATS_EN
    chk("stats_zero", push_count, 32'd0);
    for (int i = 0; i < 257; i++) begin
      data_in = 6'b11_0000 | 6'(i[3:0]); valid_in = 1'b1;
      expect_push(data_in);
      step();
    end
    valid_in = 1'b0;
    step();
    step();
    chk("stats_wrap", push_count, 32'h0100_0000);
`endif

    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vc_demux.md
Name: vc_demux

Overview:
- Writer-side counterpart of the virtual-channel arbiter.
- Takes a single incoming word stream, decodes the 2-bit class field of each word, and pushes the word into one of four virtual-channel FIFOs (vchannel0..3).
- Enforces backpressure from the FIFO full/almost-full flags toward the upstream source with a one-word stall buffer.
- Sits between the link input and the four VC FIFOs whose empty flags the arbiter reads.

Parameters:
- DATA_WIDTH, 6: word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the VC class field.
- CLASS_LSB, DATA_WIDTH-2: LSB position of the 2-bit class field.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- enb  input  1  block enable; 0 freezes accept and push.
- data_in  input  DATA_WIDTH  incoming word.
- valid_in  input  1  data_in valid this cycle.
- full_vchannel0..3  input  1 each  VC FIFO full flags.
- almost_full_vchannel0..3  input  1 each  VC FIFO almost-full flags.
- data_out  output  DATA_WIDTH  word written to the FIFOs (shared bus, registered).
- push_vchannel  output  4  one-hot push strobes; bit n writes vchannel n (registered).
- pause  output  1  backpressure to upstream (combinational from state and flags).
- error  output  1  sticky protocol-violation flag (registered).
- state  output  2  current FSM state, for debug.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RESET.
  - data_out=0, push_vchannel=4'b0000, error=0, hold register=0.
  - pause=1.
- First rising clk after rst deasserts: RESET->IDLE.
- Class decode: sel = word[CLASS_LSB+1:CLASS_LSB]; 00->vchannel0 … 11->vchannel3.
- pause = (state!=IDLE) | (enb==0) | any almost_full_vchannelN.
- Accept condition: valid_in & enb & !pause, sampled at the rising edge.
- IDLE:
  - Accept and full_vchannel[sel]=0: next edge push_vchannel<=onehot(sel), data_out<=data_in; stay IDLE. Latency is 1 cycle from input to push.
  - Accept and full_vchannel[sel]=1: capture word into hold register, push_vchannel<=0; go STALL.
  - No accept: push_vchannel<=0.
- STALL:
  - pause=1.
  - Each edge with enb=1, check full of the held word's VC.
  - VC full: push_vchannel<=0, stay in STALL.
  - VC not full: push held word (onehot, data_out<=hold); go DRAIN.
- DRAIN: one cycle. push_vchannel<=0, pause=1, then go IDLE. This gives the FIFO one cycle to update its flags.
- enb=0 in any state:
  - push_vchannel<=0; data_out and hold register retained.
  - state held; no accept.
- Protocol violation: valid_in=1 while pause=1 and state!=RESET.
  - Word dropped; error<=1.
  - error is sticky until rst.
- Same-cycle events:
  - A stalled word's release and a new input never coincide, because pause=1 through STALL and DRAIN.
  - Back-to-back words to different VCs in IDLE produce consecutive one-hot pushes, one per cycle.
- push_vchannel is always one-hot or zero; it is never asserted toward a VC whose full flag was 1 at the deciding edge.
- Reset asserted mid-STALL: held word discarded, outputs return to reset values immediately.

Optional Feature:
- Macro: VC_DEMUX_STATS_EN.
- Defined:
  - Adds output push_count [31:0]: four 8-bit counters packed {vc3,vc2,vc1,vc0}.
  - Counter n increments on each push_vchannel[n] pulse, wraps 255->0, resets to 0.
  - Dropped words are not counted.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release -> push=0000, data_out=0, error=0; pause=1 during reset, pause=0 one cycle after release with all flags 0.
- Routing: words 6'b00_0101, 01_1010, 10_0011, 11_1111 on consecutive cycles, no flags -> push 0001, 0010, 0100, 1000 on the following cycles with data_out matching each word.
- Full stall: full_vchannel2=1, send 6'b10_0110 -> push=0000, pause=1, state=STALL; drop full_vchannel2 after 4 cycles -> next edge push=0100, data_out=6'b10_0110, then one DRAIN cycle, then pause=0.
- Almost-full backpressure: almost_full_vchannel1=1 -> pause=1 while in IDLE; a word driven with valid_in=1 is dropped, error=1 and stays 1; no push occurs.
- Enable freeze: enb=0 during STALL with full cleared -> no push, state held; enb=1 -> held word pushed on the next edge.
- Stats (VC_DEMUX_STATS_EN): 257 pushes to vchannel3 -> push_count[31:24]=1, other counters 0.
